// File: rtl/hp0_read_arbiter_if.sv
//------------------------------------------------------------------------------
// hp0_read_arbiter_if
//
// Groups the two requester handshakes and the HP0 read DMA control signals
// that connect to the HP0 read arbiter.
//
// Parameters
//   ADDR_W : width of the DDR byte-address buses
//   LEN_W  : width of the transfer byte-count buses
//
// Signals
//   reqN_start   requester N start level (new request on 0->1)
//   reqN_addr    requester N DDR byte address
//   reqN_len     requester N transfer byte count
//   reqN_done    one-cycle completion pulse back to requester N
//   dma_ap_start DMA start, held until dma_ap_done
//   dma_addr     address forwarded to the DMA
//   dma_len      byte count forwarded to the DMA
//   dma_ap_done  DMA completion pulse
//   grant        one-hot DMA owner (00 when idle)
//   busy         arbiter is serving or finishing a transfer
//   timeout_err  sticky watchdog error
//
// Modports
//   master : arbiter side, drives the DMA controls and the done pulses
//   slave  : environment side, the requesters and the DMA engine
//------------------------------------------------------------------------------
interface hp0_read_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LEN_W  = 32
);
   logic              req0_start;
   logic [ADDR_W-1:0] req0_addr;
   logic [LEN_W-1:0]  req0_len;
   logic              req0_done;

   logic              req1_start;
   logic [ADDR_W-1:0] req1_addr;
   logic [LEN_W-1:0]  req1_len;
   logic              req1_done;

   logic              dma_ap_start;
   logic [ADDR_W-1:0] dma_addr;
   logic [LEN_W-1:0]  dma_len;
   logic              dma_ap_done;

   logic [1:0]        grant;
   logic              busy;
   logic              timeout_err;

   modport master (
      input  req0_start, req0_addr, req0_len,
      input  req1_start, req1_addr, req1_len,
      input  dma_ap_done,
      output req0_done, req1_done,
      output dma_ap_start, dma_addr, dma_len,
      output grant, busy, timeout_err
   );

   modport slave (
      output req0_start, req0_addr, req0_len,
      output req1_start, req1_addr, req1_len,
      output dma_ap_done,
      input  req0_done, req1_done,
      input  dma_ap_start, dma_addr, dma_len,
      input  grant, busy, timeout_err
   );
endinterface

// File: rtl/hp0_read_arbiter.sv
//------------------------------------------------------------------------------
// hp0_read_arbiter
//
// Shares the single AXI4 HP0 read DMA engine (ap_start/ap_done handshake)
// between port 0 (bias/weight fetch) and port 1 (input feature-map loader).
// Each port's start edge is captured as a pending request; requests are
// served round-robin, the winner's address/length are latched and forwarded,
// dma_ap_start is held until dma_ap_done, and the served port receives a
// one-cycle done pulse. A one-cycle GAP state guarantees at least two low
// cycles of dma_ap_start between transfers.
//
// Parameters
//   ADDR_W         : address bus width
//   LEN_W          : byte-count bus width
//   TIMEOUT_CYCLES : watchdog limit in BUSY cycles (watchdog builds only)
//
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hp0_read_arbiter_if.master (requesters, DMA control, status)
//
// Build option
//   HP0_ARB_WATCHDOG_EN : when defined, a BUSY cycle counter aborts a transfer
//   that gets no dma_ap_done within TIMEOUT_CYCLES cycles and sets the sticky
//   timeout_err. When undefined, BUSY waits indefinitely and timeout_err is 0.
//------------------------------------------------------------------------------
module hp0_read_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned LEN_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic               clk,
   input  logic               rst_n,
   hp0_read_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [1:0]        req_start;
   logic [1:0]        prev_start;
   logic [1:0]        req_edge;
   logic [1:0]        pending;
   logic [1:0]        pending_nxt;

   logic              last_grant;
   logic              last_grant_nxt;
   logic              win;
   logic [1:0]        win_oh;
   logic              take;
   logic              wd_fire;

   logic              dma_start_q;
   logic              dma_start_nxt;
   logic [ADDR_W-1:0] dma_addr_q;
   logic [ADDR_W-1:0] dma_addr_nxt;
   logic [LEN_W-1:0]  dma_len_q;
   logic [LEN_W-1:0]  dma_len_nxt;
   logic [1:0]        grant_q;
   logic [1:0]        grant_nxt;
   logic [1:0]        done_q;
   logic [1:0]        done_nxt;

   assign req_start = {bus.req1_start, bus.req0_start};
   assign req_edge  = req_start & ~prev_start;

   // A grant is issued only from IDLE, using the registered pending flags.
   assign take   = (state == ST_IDLE) && (pending != 2'b00);
   // On a tie the port that was not served last wins; otherwise the single
   // pending port wins.
   assign win    = (pending == 2'b11) ? ~last_grant : pending[1];
   assign win_oh = win ? 2'b10 : 2'b01;

   // A fresh edge always records a request, even on the port being served
   // right now, so it is picked up in a later round. Otherwise a request is
   // consumed by its grant or dropped when the requester withdraws its start.
   always_comb begin : pending_logic
      pending_nxt = pending;
      for (int i = 0; i < 2; i++) begin
         if (req_edge[i]) begin
            pending_nxt[i] = 1'b1;
         end else if (take && win_oh[i]) begin
            pending_nxt[i] = 1'b0;
         end else if (!req_start[i]) begin
            pending_nxt[i] = 1'b0;
         end
      end
   end

   always_comb begin : fsm_next
      state_nxt      = state;
      dma_start_nxt  = dma_start_q;
      dma_addr_nxt   = dma_addr_q;
      dma_len_nxt    = dma_len_q;
      grant_nxt      = grant_q;
      last_grant_nxt = last_grant;
      done_nxt       = 2'b00;
      case (state)
         ST_IDLE: begin
            if (take) begin
               dma_addr_nxt   = win ? bus.req1_addr : bus.req0_addr;
               dma_len_nxt    = win ? bus.req1_len  : bus.req0_len;
               dma_start_nxt  = 1'b1;
               grant_nxt      = win_oh;
               last_grant_nxt = win;
               state_nxt      = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // A watchdog abort finishes the transfer exactly like a normal
            // completion so the requester is never left waiting.
            if (bus.dma_ap_done || wd_fire) begin
               dma_start_nxt = 1'b0;
               done_nxt      = grant_q;
               state_nxt     = ST_GAP;
            end
         end
         ST_GAP: begin
            grant_nxt = 2'b00;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         state       <= ST_IDLE;
         prev_start  <= 2'b00;
         pending     <= 2'b00;
         // Port 0 wins the first tie after reset.
         last_grant  <= 1'b1;
         dma_start_q <= 1'b0;
         dma_addr_q  <= '0;
         dma_len_q   <= '0;
         grant_q     <= 2'b00;
         done_q      <= 2'b00;
      end else begin
         state       <= state_nxt;
         prev_start  <= req_start;
         pending     <= pending_nxt;
         last_grant  <= last_grant_nxt;
         dma_start_q <= dma_start_nxt;
         dma_addr_q  <= dma_addr_nxt;
         dma_len_q   <= dma_len_nxt;
         grant_q     <= grant_nxt;
         done_q      <= done_nxt;
      end
   end

`ifdef HP0_ARB_WATCHDOG_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] wd_cnt;
   logic             timeout_q;

   // The counter holds the number of BUSY edges already seen; the abort
   // happens on the TIMEOUT_CYCLES-th BUSY edge unless the DMA finishes.
   assign wd_fire = (state == ST_BUSY) && !bus.dma_ap_done &&
                    (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin : watchdog
      if (!rst_n) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == ST_BUSY) begin
            wd_cnt <= wd_cnt + 1'b1;
         end else begin
            wd_cnt <= '0;
         end
         if (wd_fire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.timeout_err = timeout_q;
`else
   logic unused_timeout;
   assign unused_timeout  = ^TIMEOUT_CYCLES;
   assign wd_fire         = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.dma_ap_start = dma_start_q;
   assign bus.dma_addr     = dma_addr_q;
   assign bus.dma_len      = dma_len_q;
   assign bus.grant        = grant_q;
   assign bus.req0_done    = done_q[0];
   assign bus.req1_done    = done_q[1];
   assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_hp0_read_arbiter.sv
`timescale 1ns/1ps
module tb_hp0_read_arbiter;

   localparam int AW    = 32;
   localparam int LW    = 32;
   localparam int TB_TO = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hp0_read_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) ifc ();

   hp0_read_arbiter #(
      .ADDR_W        (AW),
      .LEN_W         (LW),
      .TIMEOUT_CYCLES(TB_TO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // DMA responder: answers dma_ap_start after resp_lat+1 high cycles, and
   // emits an extra done pulse whenever spur_req is bumped.
   bit resp_on  = 1'b0;
   int resp_lat = 0;
   int spur_req = 0;

   initial begin : responder
      int cnt;
      int seen;
      cnt  = 0;
      seen = 0;
      ifc.dma_ap_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ifc.dma_ap_done = 1'b0;
         if (spur_req != seen) begin
            seen = spur_req;
            ifc.dma_ap_done = 1'b1;
         end else if (resp_on && ifc.dma_ap_start) begin
            if (cnt >= resp_lat) begin
               ifc.dma_ap_done = 1'b1;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Reference model: per-port request flags, the current owner of the DMA
   // (-1 when free) and a pending done-pulse cycle. It is evaluated on each
   // falling edge with the inputs the next rising edge will sample.
   int              m_owner;
   int              m_grantp;
   int              m_last;
   bit              m_gap;
   bit              m_start;
   bit [1:0]        m_done;
   bit              m_pend [2];
   bit              m_prev [2];
   logic [AW-1:0]   m_addr;
   logic [LW-1:0]   m_len;
   bit              m_terr;
`ifdef HP0_ARB_WATCHDOG_EN
   int              m_cnt;
`endif

   task automatic m_reset();
      m_owner  = -1;
      m_grantp = -1;
      m_last   = 1;
      m_gap    = 1'b0;
      m_start  = 1'b0;
      m_done   = 2'b00;
      m_pend   = '{1'b0, 1'b0};
      m_prev   = '{1'b0, 1'b0};
      m_addr   = '0;
      m_len    = '0;
      m_terr   = 1'b0;
   endtask

   task automatic m_step();
      bit s [2];
      bit dn;
      bit tmo;
      bit nw;
      int g;
      s[0] = ifc.req0_start;
      s[1] = ifc.req1_start;
      dn   = ifc.dma_ap_done;
      tmo  = 1'b0;
      g    = -1;
      m_done = 2'b00;
      if (m_gap) begin
         m_gap    = 1'b0;
         m_grantp = -1;
      end else if (m_owner >= 0) begin
`ifdef HP0_ARB_WATCHDOG_EN
         tmo = !dn && (m_cnt == TB_TO - 1);
         if (!dn && !tmo) m_cnt++;
`endif
         if (dn || tmo) begin
            m_done[m_owner] = 1'b1;
            m_start = 1'b0;
            m_gap   = 1'b1;
            m_owner = -1;
            if (tmo) m_terr = 1'b1;
         end
      end else if (m_pend[0] || m_pend[1]) begin
         g = (m_pend[0] && m_pend[1]) ? (1 - m_last) : (m_pend[0] ? 0 : 1);
         m_owner  = g;
         m_grantp = g;
         m_start  = 1'b1;
         m_addr   = (g == 1) ? ifc.req1_addr : ifc.req0_addr;
         m_len    = (g == 1) ? ifc.req1_len  : ifc.req0_len;
         m_last   = g;
`ifdef HP0_ARB_WATCHDOG_EN
         m_cnt    = 0;
`endif
      end
      for (int p = 0; p < 2; p++) begin
         nw = s[p] && !m_prev[p];
         m_pend[p] = nw || (m_pend[p] && s[p] && (g != p));
         m_prev[p] = s[p];
      end
   endtask

   initial begin : model
      logic [1:0] eg;
      m_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) m_reset();
         eg = (m_grantp < 0) ? 2'b00 : ((m_grantp == 0) ? 2'b01 : 2'b10);
         check("m_start", 64'(ifc.dma_ap_start), 64'(m_start));
         check("m_grant", 64'(ifc.grant), 64'(eg));
         check("m_done0", 64'(ifc.req0_done), 64'(m_done[0]));
         check("m_done1", 64'(ifc.req1_done), 64'(m_done[1]));
         check("m_busy", 64'(ifc.busy), 64'((m_owner >= 0) || m_gap));
         check("m_addr", 64'(ifc.dma_addr), 64'(m_addr));
         check("m_len", 64'(ifc.dma_len), 64'(m_len));
         check("m_terr", 64'(ifc.timeout_err), 64'(m_terr));
         if (rst_n) m_step();
      end
   end

   task automatic wait_start(input logic val, input int maxc, output int n);
      n = 0;
      while (ifc.dma_ap_start !== val) begin
         if (n >= maxc) begin
            check("wait_start", 64'(ifc.dma_ap_start), 64'(val));
            n = -1;
            return;
         end
         tick();
         n++;
      end
   endtask

   initial begin : stim
      int n;
      int hi;
      int d0;
      int d1;
      int rises;
      int acc;
      logic prev_s;

      ifc.req0_start = 1'b0;
      ifc.req0_addr  = '0;
      ifc.req0_len   = '0;
      ifc.req1_start = 1'b0;
      ifc.req1_addr  = '0;
      ifc.req1_len   = '0;

      // reset state
      repeat (3) tick();
      check("rst_start", 64'(ifc.dma_ap_start), 64'(0));
      check("rst_addr", 64'(ifc.dma_addr), 64'(0));
      check("rst_len", 64'(ifc.dma_len), 64'(0));
      check("rst_grant", 64'(ifc.grant), 64'(0));
      check("rst_done", 64'({ifc.req1_done, ifc.req0_done}), 64'(0));
      check("rst_busy", 64'(ifc.busy), 64'(0));
      check("rst_terr", 64'(ifc.timeout_err), 64'(0));
      rst_n = 1'b1;

      // simultaneous requests: port 0 first, then port 1 after a 2-cycle gap
      resp_on  = 1'b1;
      resp_lat = 3;
      ifc.req0_addr = 32'h2000_0000;  ifc.req0_len = 32'h80;
      ifc.req1_addr = 32'h3000_0000;  ifc.req1_len = 32'h100;
      ifc.req0_start = 1'b1;
      ifc.req1_start = 1'b1;
      tick();
      tick();
      check("tie_grant0", 64'(ifc.grant), 64'(2'b01));
      check("tie_addr0", 64'(ifc.dma_addr), 64'(32'h2000_0000));
      wait_start(1'b0, 40, n);
      check("tie_done0", 64'(ifc.req0_done), 64'(1));
      wait_start(1'b1, 10, n);
      check("tie_gap", 64'(n), 64'(2));
      check("tie_grant1", 64'(ifc.grant), 64'(2'b10));
      check("tie_addr1", 64'(ifc.dma_addr), 64'(32'h3000_0000));
      check("tie_len1", 64'(ifc.dma_len), 64'(32'h100));
      ifc.req0_start = 1'b0;
      ifc.req1_start = 1'b0;
      wait_start(1'b0, 40, n);
      check("tie_done1", 64'(ifc.req1_done), 64'(1));
      repeat (3) tick();
      ifc.req0_start = 1'b1;
      ifc.req1_start = 1'b1;
      tick();
      tick();
      check("tie2_grant", 64'(ifc.grant), 64'(2'b01));
      ifc.req0_start = 1'b0;
      ifc.req1_start = 1'b0;
      wait_start(1'b0, 40, n);
      repeat (3) tick();

      // single request, DMA done 10 cycles after start
      resp_lat = 9;
      ifc.req0_addr  = 32'h1000_0000;
      ifc.req0_len   = 32'h400;
      ifc.req0_start = 1'b1;
      tick();
      check("t1_lat1", 64'(ifc.dma_ap_start), 64'(0));
      tick();
      check("t1_start", 64'(ifc.dma_ap_start), 64'(1));
      check("t1_addr", 64'(ifc.dma_addr), 64'(32'h1000_0000));
      check("t1_len", 64'(ifc.dma_len), 64'(32'h400));
      check("t1_grant", 64'(ifc.grant), 64'(2'b01));
      hi = 1; d0 = 0; d1 = 0;
      repeat (30) begin
         tick();
         hi += int'(ifc.dma_ap_start);
         d0 += int'(ifc.req0_done);
         d1 += int'(ifc.req1_done);
      end
      check("t1_hi_cycles", 64'(hi), 64'(10));
      check("t1_done0_pulses", 64'(d0), 64'(1));
      check("t1_done1_pulses", 64'(d1), 64'(0));
      ifc.req0_start = 1'b0;
      repeat (2) tick();

      // drop-and-reassert during BUSY with a new address
      resp_lat = 6;
      ifc.req0_addr  = 32'h4000_0000;
      ifc.req0_len   = 32'h200;
      ifc.req0_start = 1'b1;
      wait_start(1'b1, 10, n);
      check("t3_lat", 64'(n), 64'(2));
      tick();
      ifc.req0_start = 1'b0;
      tick();
      ifc.req0_start = 1'b1;
      ifc.req0_addr  = 32'h4100_0000;
      ifc.req0_len   = 32'h300;
      tick();
      check("t3_hold_addr", 64'(ifc.dma_addr), 64'(32'h4000_0000));
      wait_start(1'b0, 40, n);
      wait_start(1'b1, 10, n);
      check("t3_gap", 64'(n), 64'(2));
      check("t3_addr2", 64'(ifc.dma_addr), 64'(32'h4100_0000));
      check("t3_len2", 64'(ifc.dma_len), 64'(32'h300));
      ifc.req0_start = 1'b0;
      wait_start(1'b0, 40, n);
      repeat (3) tick();

      // port 1 withdraws before grant while port 0 is busy
      resp_lat = 8;
      ifc.req0_start = 1'b1;
      wait_start(1'b1, 10, n);
      ifc.req0_start = 1'b0;
      tick();
      ifc.req1_start = 1'b1;
      tick();
      ifc.req1_start = 1'b0;
      rises = 0; d0 = 0; d1 = 0; prev_s = ifc.dma_ap_start;
      repeat (30) begin
         tick();
         if (ifc.dma_ap_start && !prev_s) rises++;
         prev_s = ifc.dma_ap_start;
         d0 += int'(ifc.req0_done);
         d1 += int'(ifc.req1_done);
      end
      check("t4_rises", 64'(rises), 64'(0));
      check("t4_done0", 64'(d0), 64'(1));
      check("t4_done1", 64'(d1), 64'(0));

      // spurious dma_ap_done while idle
      spur_req++;
      acc = 0;
      repeat (5) begin
         tick();
         acc += int'(ifc.dma_ap_start) + int'(ifc.busy) + int'(ifc.grant != 2'b00)
              + int'(ifc.req0_done) + int'(ifc.req1_done);
      end
      check("t5_spurious", 64'(acc), 64'(0));

      // reset asserted mid-transfer
      resp_lat = 20;
      ifc.req1_start = 1'b1;
      wait_start(1'b1, 10, n);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_start", 64'(ifc.dma_ap_start), 64'(0));
      check("t5_rst_grant", 64'(ifc.grant), 64'(0));
      check("t5_rst_addr", 64'(ifc.dma_addr), 64'(0));
      check("t5_rst_len", 64'(ifc.dma_len), 64'(0));
      check("t5_rst_busy", 64'(ifc.busy), 64'(0));
      ifc.req1_start = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      spur_req++;
      acc = 0;
      repeat (5) begin
         tick();
         acc += int'(ifc.dma_ap_start) + int'(ifc.busy) + int'(ifc.req1_done);
      end
      check("t5_after_rst", 64'(acc), 64'(0));

`ifdef HP0_ARB_WATCHDOG_EN
      // watchdog: DMA never answers
      resp_on = 1'b0;
      ifc.req0_start = 1'b1;
      wait_start(1'b1, 10, n);
      hi = 1; d0 = 0;
      repeat (40) begin
         tick();
         hi += int'(ifc.dma_ap_start);
         d0 += int'(ifc.req0_done);
      end
      check("wd_hi_cycles", 64'(hi), 64'(TB_TO));
      check("wd_done0", 64'(d0), 64'(1));
      check("wd_terr", 64'(ifc.timeout_err), 64'(1));
      ifc.req0_start = 1'b0;
      resp_on = 1'b1;
      repeat (5) tick();
      check("wd_terr_sticky", 64'(ifc.timeout_err), 64'(1));
`endif

      // randomized traffic, checked cycle by cycle against the model
      resp_on = 1'b1;
      repeat (800) begin
         tick();
         if (!ifc.req0_start) ifc.req0_start = ($urandom_range(0, 4) == 0);
         else                 ifc.req0_start = ($urandom_range(0, 6) != 0);
         if (!ifc.req1_start) ifc.req1_start = ($urandom_range(0, 4) == 0);
         else                 ifc.req1_start = ($urandom_range(0, 6) != 0);
         if ($urandom_range(0, 2) == 0) begin
            ifc.req0_addr = $urandom;
            ifc.req0_len  = $urandom;
         end
         if ($urandom_range(0, 2) == 0) begin
            ifc.req1_addr = $urandom;
            ifc.req1_len  = $urandom;
         end
         resp_lat = int'($urandom_range(0, 6));
         if ($urandom_range(0, 28) == 0) spur_req++;
      end
      ifc.req0_start = 1'b0;
      ifc.req1_start = 1'b0;
      repeat (30) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hp0_read_arbiter.md
# hp0_read_arbiter

Shares the single AXI4 HP0 read DMA engine (HLS-style ap_start/ap_done) between two requesters: port 0 (bias/weight fetch controller) and port 1 (input feature-map loader). It detects each requester's start edge, arbitrates round-robin, forwards the winner's address and byte count to the DMA, holds the DMA start until done, and returns a one-cycle done pulse to the served requester. It sits between the layer controllers and the HP0 DMA instance.

## Interface
- ADDR_W, 32, width of address buses
- LEN_W, 32, width of transfer byte-count buses
- TIMEOUT_CYCLES, 1048576, watchdog limit in cycles (used only with HP0_ARB_WATCHDOG_EN)

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req0_start  in  1  requester 0 start level; a new request is a 0→1 transition
- req0_addr  in  ADDR_W  requester 0 DDR byte address
- req0_len  in  LEN_W  requester 0 transfer byte count
- req0_done  out  1  one-cycle pulse: requester 0 transfer finished
- req1_start / req1_addr / req1_len / req1_done  same as port 0, for requester 1
- dma_ap_start  out  1  DMA start, held high until dma_ap_done
- dma_addr  out  ADDR_W  address forwarded to DMA
- dma_len  out  LEN_W  byte count forwarded to DMA
- dma_ap_done  in  1  DMA completion pulse
- grant  out  2  one-hot owner of the DMA (00 when idle)
- busy  out  1  high in BUSY and GAP states
- timeout_err  out  1  sticky watchdog error (constant 0 without the macro)

## Operation
- Edge detect: per port, registered prev_start; pendingN set at edge where reqN_start=1 and prev=0.
- pendingN cleared when granted, or when reqN_start is sampled 0 while pending and not granted (withdrawn).
- States: IDLE, BUSY, GAP.
- IDLE: if any pending, pick winner; both pending → port ≠ last_grant. Latch dma_addr/dma_len from winner's addr/len, dma_ap_start←1, grant←winner, last_grant←winner, → BUSY.
- BUSY: dma_addr/dma_len/grant stable. On dma_ap_done=1: dma_ap_start←0, reqN_done←1 for granted port, → GAP.
- GAP: done pulse ends, grant←00, → IDLE.
- dma_ap_done outside BUSY is ignored.
- A new edge on the port currently served is recorded as pending and served in a later round (other port first if also pending).
- Requester dropping start during BUSY does not abort; transfer completes and done pulses normally.
- addr/len are sampled only at grant; later changes have no effect on the running transfer.

## Timing
- Reset (async assert): state=IDLE, dma_ap_start=0, dma_addr=0, dma_len=0, grant=00, req0_done=0, req1_done=0, busy=0, timeout_err=0, pending=0, prev_start=0, last_grant=1 (port 0 wins first tie).
- Latency: reqN_start rising sampled at edge E0 → pending after E0 → dma_ap_start high after E1.
- dma_ap_done sampled at edge D → dma_ap_start low and reqN_done high after D; done low and grant=00 after D+1; next dma_ap_start earliest after D+2 (≥2 low cycles between transfers).
- One-cycle low on reqN_start followed by high (drop-and-reassert) creates a new request.
- Reset deassertion mid-transfer: arbiter restarts in IDLE; in-flight DMA completion is ignored.

## Configuration
- HP0_ARB_WATCHDOG_EN defined: cycle counter cleared on entering BUSY, increments in BUSY; reaching TIMEOUT_CYCLES−1 without dma_ap_done → dma_ap_start←0, timeout_err←1 (sticky until reset), reqN_done pulsed, → GAP.
- Not defined: no counter, BUSY waits indefinitely, timeout_err tied 0, TIMEOUT_CYCLES unused.

## Test plan
- req0 rises with addr=0x1000_0000, len=0x400; DMA done 10 cycles after start → dma_ap_start high 2 cycles after req edge, dma_addr=0x1000_0000, dma_len=0x400, grant=01, req0_done single pulse, req1_done stays 0.
- req0 and req1 rise same cycle → port 0 served first, then port 1 with dma_ap_start low exactly 2 cycles in between; next tie grants port 0 again only after port 1 served.
- req0 held high, dropped 1 cycle and reasserted with new addr (bias→weight pattern) during BUSY → second transfer issued after first done with new addr.
- req1 pulses high then falls before grant while port 0 BUSY → no port-1 transfer, req1_done never asserts.
- Spurious dma_ap_done in IDLE → no state change; rst_n asserted mid-BUSY → all outputs zero immediately.
- With HP0_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=16, no dma_ap_done → dma_ap_start falls after 16 BUSY cycles, timeout_err=1 sticky, req0_done pulses once.
